ccc_lock_rst_ctrl: RTL and testbench
====================================

CCC_LOCK_RST_CTRL -- requirements
Module: ccc_lock_rst_ctrl

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 16: consecutive synchronized-LOCK-high cycles required to qualify lock (legal range 1..1024).
REQ-002 SHALL have parameter RST_HOLD, default 64: cycles FAB_RESET_N is held low after lock qualifies (legal range 1..1024).
REQ-003 SHALL have parameter LOSS_CNT_W, default 8: width of LOSS_COUNT.
REQ-004 SHALL have port CLK  input  1  fabric clock, driven from CCC GL0; sole clock.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port LOCK  input  1  CCC PLL lock, asynchronous to CLK.
REQ-007 SHALL have port SW_RST_REQ  input  1  software fabric-reset request, level-sampled.
REQ-008 SHALL have port FAB_RESET_N  output  1  active-low fabric reset to downstream logic.
REQ-009 SHALL have port FAB_READY  output  1  high when fabric is released from reset.
REQ-010 SHALL have port LOCK_LOST  output  1  one-cycle pulse on lock loss while running.
REQ-011 SHALL have port LOSS_COUNT  output  LOSS_CNT_W  saturating count of lock-loss events.
REQ-012 SHALL have port STATE  output  2  current FSM state encoding.

Function
REQ-013 SHALL synchronize LOCK through two CLK flops; lock_s is the second flop; no other logic uses LOCK directly.
REQ-014 SHALL implement FSM WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3 with one shared cycle counter.
REQ-015 WAIT_LOCK: counter=0; lock_s=1 -> FILTER.
REQ-016 FILTER: lock_s=0 -> WAIT_LOCK, counter cleared; counter==LOCK_FILTER-1 -> HOLD, counter cleared; else counter+1.
REQ-017 HOLD: lock_s=0 -> WAIT_LOCK; counter==RST_HOLD-1 -> RUN, counter cleared; else counter+1.
REQ-018 RUN: lock_s=0 -> WAIT_LOCK with LOCK_LOST=1 for exactly one cycle; SW_RST_REQ=1 -> HOLD, counter cleared; else stay.
REQ-019 In RUN, simultaneous lock_s=0 and SW_RST_REQ=1 -> lock loss wins (WAIT_LOCK, LOCK_LOST pulse).
REQ-020 SW_RST_REQ SHALL be ignored in WAIT_LOCK, FILTER, HOLD.
REQ-021 All outputs SHALL be registered; FAB_RESET_N=1 and FAB_READY=1 iff STATE==RUN, updated on the same edge as STATE.
REQ-022 Latency: with LOCK stable high before edge k, STATE reaches FILTER at edge k+2, HOLD at edge k+2+LOCK_FILTER, RUN at edge k+2+LOCK_FILTER+RST_HOLD.
REQ-023 LOSS_COUNT SHALL increment by 1 on each LOCK_LOST pulse and saturate at all-ones (no wrap).
REQ-024 A LOCK glitch shorter than LOCK_FILTER cycles during FILTER SHALL restart qualification from WAIT_LOCK.

Reset
REQ-025 RESET=1 at an edge SHALL force STATE=WAIT_LOCK, counter=0, sync flops=0, FAB_RESET_N=0, FAB_READY=0, LOCK_LOST=0, LOSS_COUNT=0.
REQ-026 RESET SHALL take priority over all FSM transitions; RESET asserted in RUN SHALL NOT produce LOCK_LOST or increment LOSS_COUNT.
REQ-027 After RESET deasserts, qualification SHALL restart per REQ-022.

Configuration
REQ-028 Macro CCC_LOCK_LOSS_CNT_EN defined: LOSS_COUNT counter implemented per REQ-023.
REQ-029 Macro CCC_LOCK_LOSS_CNT_EN undefined: no counter registers; LOSS_COUNT tied to 0; LOCK_LOST unaffected.

Verification
REQ-030 Defaults; RESET released, LOCK high from edge 0 -> STATE=1 at edge 2, 2 at edge 18, 3 and FAB_RESET_N=1 at edge 82.
REQ-031 LOCK high 10 cycles, low 3, then high steady -> returns to WAIT_LOCK, FAB_RESET_N stays 0 until full 16+64 qualification after re-rise.
REQ-032 In RUN, LOCK low -> two edges later LOCK_LOST=1 one cycle, FAB_RESET_N=0, LOSS_COUNT 0->1; repeat 300 times with LOSS_CNT_W=8 -> LOSS_COUNT=255.
REQ-033 In RUN, SW_RST_REQ one cycle -> FAB_RESET_N=0 for 64 cycles, then 1; LOSS_COUNT unchanged; same cycle as lock_s=0 -> LOCK_LOST=1, STATE=0.
REQ-034 RESET asserted in RUN -> next edge all outputs at REQ-025 values, LOCK_LOST stays 0; with CCC_LOCK_LOSS_CNT_EN undefined, LOSS_COUNT=0 throughout REQ-032.

Source files
------------

// File: rtl/ccc_lock_rst_ctrl.sv
// CCC lock qualifier and fabric reset sequencer: filters PLL LOCK, holds fabric reset, flags lock loss.
// Optional macro CCC_LOCK_LOSS_CNT_EN adds the saturating LOSS_COUNT counter (tied to 0 otherwise).
module ccc_lock_rst_ctrl #(
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned RST_HOLD    = 64,
    parameter int unsigned LOSS_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOCK,
    input  logic                  SW_RST_REQ,
    output logic                  FAB_RESET_N,
    output logic                  FAB_READY,
    output logic                  LOCK_LOST,
    output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
    output logic [1:0]            STATE
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_FILTER    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // Both thresholds are at most 1024, so the last count value fits in 10 bits.
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, lock_s_q;
    logic             fab_q, fab_d;
    logic             lost_q, lost_d;

    // State, shared counter, LOCK synchronizer and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
            fab_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= LOCK;
            lock_s_q <= sync1_q;
            fab_q    <= fab_d;
            lost_q   <= lost_d;
        end
    end

    // Next state, counter and output intents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) state_d = ST_FILTER;
            end
            ST_FILTER: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss outranks a concurrent software reset request.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = 1'b1;
                end else if (SW_RST_REQ) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        fab_d = (state_d == ST_RUN);
    end

`ifdef CCC_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_q;

    // Saturating lock-loss event counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            loss_q <= '0;
        end else if (lost_d && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign LOSS_COUNT = loss_q;
`else
    assign LOSS_COUNT = '0;
`endif

    assign STATE       = 2'(state_q);
    assign FAB_RESET_N = fab_q;
    assign FAB_READY   = fab_q;
    assign LOCK_LOST   = lost_q;

endmodule

// File: tb/tb_ccc_lock_rst_ctrl.sv
// Self-checking bench for ccc_lock_rst_ctrl at default parameters; honours CCC_LOCK_LOSS_CNT_EN.
module tb_ccc_lock_rst_ctrl;

    logic       CLK;
    logic       RESET;
    logic       LOCK;
    logic       SW_RST_REQ;
    logic       FAB_RESET_N;
    logic       FAB_READY;
    logic       LOCK_LOST;
    logic [7:0] LOSS_COUNT;
    logic [1:0] STATE;

    typedef struct packed {
        logic [1:0] st;
        logic       fab_n;
        logic       ready;
        logic       lost;
        logic [7:0] lc;
    } obs_t;

    typedef struct {
        logic lock;
        logic sw;
        int   n;
        obs_t exp;
    } vec_t;

    obs_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ccc_lock_rst_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LOCK        (LOCK),
        .SW_RST_REQ  (SW_RST_REQ),
        .FAB_RESET_N (FAB_RESET_N),
        .FAB_READY   (FAB_READY),
        .LOCK_LOST   (LOCK_LOST),
        .LOSS_COUNT  (LOSS_COUNT),
        .STATE       (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] lcv(input int v);
`ifdef CCC_LOCK_LOSS_CNT_EN
        return 8'(v);
`else
        return 8'(v) & 8'd0;
`endif
    endfunction

    function automatic obs_t mk(input logic [1:0] st, input logic fab, input logic lost, input int lc);
        obs_t o;
        o.st    = st;
        o.fab_n = fab;
        o.ready = fab;
        o.lost  = lost;
        o.lc    = lcv(lc);
        return o;
    endfunction

    function automatic void add(input logic lock, input logic sw, input int n, input obs_t e);
        vec_t v;
        v.lock = lock;
        v.sw   = sw;
        v.n    = n;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic lock, input logic sw);
        @(negedge CLK);
        RESET      = rst;
        LOCK       = lock;
        SW_RST_REQ = sw;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name);
        obs_t act;
        obs_t exp;
        act = {STATE, FAB_RESET_N, FAB_READY, LOCK_LOST, LOSS_COUNT};
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s: got st=%0d fab_n=%b ready=%b lost=%b lc=%0d, want st=%0d fab_n=%b ready=%b lost=%b lc=%0d",
                         name, act.st, act.fab_n, act.ready, act.lost, act.lc,
                         exp.st, exp.fab_n, exp.ready, exp.lost, exp.lc);
            end
        end
    endtask

    initial begin
        RESET      = 1'b1;
        LOCK       = 1'b0;
        SW_RST_REQ = 1'b0;

        // Bring-up to RUN: FILTER at edge 2, HOLD at 18, RUN at 82.
        add(1, 0, 2,  mk(0, 0, 0, 0));
        add(1, 0, 1,  mk(1, 0, 0, 0));
        add(1, 0, 15, mk(1, 0, 0, 0));
        add(1, 0, 1,  mk(2, 0, 0, 0));
        add(1, 0, 63, mk(2, 0, 0, 0));
        add(1, 0, 1,  mk(3, 1, 0, 0));
        add(1, 0, 5,  mk(3, 1, 0, 0));
        // Lock loss: pulse two edges after LOCK falls, then clears.
        add(0, 0, 2,  mk(3, 1, 0, 0));
        add(0, 0, 1,  mk(0, 0, 1, 1));
        add(0, 0, 1,  mk(0, 0, 0, 1));
        // Glitch: high 10, low 3, then steady high requalifies from scratch.
        add(1, 0, 10, mk(1, 0, 0, 1));
        add(0, 0, 2,  mk(1, 0, 0, 1));
        add(0, 0, 1,  mk(0, 0, 0, 1));
        add(1, 0, 2,  mk(0, 0, 0, 1));
        add(1, 0, 1,  mk(1, 0, 0, 1));
        add(1, 0, 16, mk(2, 0, 0, 1));
        add(1, 0, 63, mk(2, 0, 0, 1));
        add(1, 0, 1,  mk(3, 1, 0, 1));
        // Software reset from RUN: 64 cycles of HOLD.
        add(1, 1, 1,  mk(2, 0, 0, 1));
        add(1, 0, 63, mk(2, 0, 0, 1));
        add(1, 0, 1,  mk(3, 1, 0, 1));
        // Lock loss and software request on the same edge.
        add(0, 0, 2,  mk(3, 1, 0, 1));
        add(0, 1, 1,  mk(0, 0, 1, 2));
        // Software request ignored in WAIT_LOCK, FILTER and HOLD.
        add(0, 1, 3,  mk(0, 0, 0, 2));
        add(1, 1, 2,  mk(0, 0, 0, 2));
        add(1, 1, 1,  mk(1, 0, 0, 2));
        add(1, 1, 16, mk(2, 0, 0, 2));
        add(1, 1, 63, mk(2, 0, 0, 2));
        add(1, 0, 1,  mk(3, 1, 0, 2));

        repeat (3) drive(1, 0, 0);
        sb.push_back(mk(0, 0, 0, 0));
        check("reset_state");

        foreach (vecs[i]) begin
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].n) drive(0, vecs[i].lock, vecs[i].sw);
            check($sformatf("vec%0d", i));
        end

        // RESET while running with LOCK dropping: no pulse, no count.
        sb.push_back(mk(0, 0, 0, 0));
        drive(1, 0, 0);
        check("rst_in_run");
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(0, 0, 0, 0));
            drive(1, 1, 0);
            check($sformatf("rst_hold%0d", i));
        end
        sb.push_back(mk(0, 0, 0, 0));
        repeat (2) drive(0, 1, 0);
        check("rst_restart_wait");
        sb.push_back(mk(1, 0, 0, 0));
        drive(0, 1, 0);
        check("rst_restart_filter");
        sb.push_back(mk(2, 0, 0, 0));
        repeat (16) drive(0, 1, 0);
        check("rst_restart_hold");
        sb.push_back(mk(2, 0, 0, 0));
        repeat (63) drive(0, 1, 0);
        check("rst_restart_hold_end");
        sb.push_back(mk(3, 1, 0, 0));
        drive(0, 1, 0);
        check("rst_restart_run");

        // 300 loss/requalify rounds: count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            int prev;
            int cur;
            prev = (i - 1 > 255) ? 255 : i - 1;
            cur  = (i > 255) ? 255 : i;
            sb.push_back(mk(3, 1, 0, prev));
            repeat (2) drive(0, 0, 0);
            check($sformatf("sat%0d_pre", i));
            sb.push_back(mk(0, 0, 1, cur));
            drive(0, 0, 0);
            check($sformatf("sat%0d_pulse", i));
            sb.push_back(mk(0, 0, 0, cur));
            drive(0, 1, 0);
            check($sformatf("sat%0d_after", i));
            sb.push_back(mk(3, 1, 0, cur));
            repeat (82) drive(0, 1, 0);
            check($sformatf("sat%0d_run", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
